// File: rtl/report_hex_frame_if.sv
// report_hex_frame_if
// Byte stream link from the hex status reporter to the UART transmitter.
//   data  : ASCII byte presented by the master
//   valid : master holds a byte on data
//   ready : slave takes the byte on a cycle where valid && ready
// Modports: master (reporter side), slave (UART side).
interface report_hex_frame_if;
    logic [7:0] data;
    logic       valid;
    logic       ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/report_hex_frame.sv
// report_hex_frame
// Periodic or on-demand ASCII status reporter. It captures NUM_CH counter
// channels and an optional pair of error words, then streams a CR/LF
// terminated uppercase hex text frame, one byte at a time, over the tx link.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   enable      : allows periodic and forced frames to start
//   force_req   : single-cycle request for a frame now
//   ch_data     : channel i at [i*CH_WIDTH +: CH_WIDTH]
//   dump_en     : append the error line when set at snapshot time
//   dump_a/b    : error words (chip result, reference result)
//   tx          : byte stream master (data/valid out, ready in)
//   busy        : frame in progress, snapshot cycle through last accept
//   overrun     : sticky, a trigger arrived while one was already pending
module report_hex_frame #(
    parameter int CLK_FREQ    = 50_000_000,
    parameter int REPORT_FREQ = 2,
    parameter int NUM_CH      = 2,
    parameter int CH_WIDTH    = 32,
    parameter int DUMP_WIDTH  = 128,
    parameter int SEQ_DIGITS  = 3
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       enable,
    input  logic                       force_req,
    input  logic [NUM_CH*CH_WIDTH-1:0] ch_data,
    input  logic                       dump_en,
    input  logic [DUMP_WIDTH-1:0]      dump_a,
    input  logic [DUMP_WIDTH-1:0]      dump_b,
    report_hex_frame_if.master         tx,
    output logic                       busy,
    output logic                       overrun
);

    localparam int REPORT_COUNT = CLK_FREQ / REPORT_FREQ;
    localparam int CNT_W        = $clog2(REPORT_COUNT);
    localparam int SEQ_W        = 4 * SEQ_DIGITS;
    localparam int CH_DIGITS    = CH_WIDTH / 4;
    localparam int DUMP_DIGITS  = DUMP_WIDTH / 4;
    localparam int CH_LEN       = 4 + CH_DIGITS;
    localparam int ERR_LEN      = 2 * DUMP_DIGITS + 5;
    localparam int POS_W        = 16;

    typedef enum logic [1:0] {IDLE, SNAP, SEND} state_t;
    // Frame sections: sequence number, channel fields, first CR/LF, error line.
    typedef enum logic [1:0] {SEG_SEQ, SEG_CH, SEG_EOL, SEG_ERR} seg_t;

    state_t                     state;
    seg_t                       seg;
    logic [3:0]                 ch_idx;
    logic [POS_W-1:0]           pos;
    logic [CNT_W-1:0]           period_cnt;
    logic                       pending;
    logic [SEQ_W-1:0]           seq;
    logic [SEQ_W-1:0]           seq_snap;
    logic [NUM_CH*CH_WIDTH-1:0] ch_snap;
    logic [DUMP_WIDTH-1:0]      dump_a_snap;
    logic [DUMP_WIDTH-1:0]      dump_b_snap;
    logic                       dump_en_snap;
    logic [7:0]                 data_q;
    logic                       valid_q;

    logic                       tick;
    logic                       trigger;
    logic                       start_ok;
    seg_t                       nxt_seg;
    logic [3:0]                 nxt_ch;
    logic [POS_W-1:0]           nxt_pos;
    logic                       last_byte;
    logic [7:0]                 nxt_byte;
    logic [POS_W-1:0]           digit;
    logic [31:0]                shift;

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    assign tx.data  = data_q;
    assign tx.valid = valid_q;
    assign busy     = (state != IDLE);

    assign tick     = enable && (period_cnt == CNT_W'(REPORT_COUNT - 1));
    assign trigger  = tick || force_req;
    // A trigger in this very cycle counts as pending, so a frame can be
    // snapped on the edge right after the trigger.
    assign start_ok = (pending || trigger) && enable;

    // Advance the byte cursor by one position within the frame layout and
    // flag the final byte, which depends on whether the error line was snapped.
    always_comb begin
        nxt_seg   = seg;
        nxt_ch    = ch_idx;
        nxt_pos   = pos + POS_W'(1);
        last_byte = 1'b0;
        unique case (seg)
            SEG_SEQ: begin
                if (pos == POS_W'(SEQ_DIGITS - 1)) begin
                    nxt_seg = SEG_CH;
                    nxt_ch  = 4'd0;
                    nxt_pos = '0;
                end
            end
            SEG_CH: begin
                if (pos == POS_W'(CH_LEN - 1)) begin
                    nxt_pos = '0;
                    if (ch_idx == 4'(NUM_CH - 1)) nxt_seg = SEG_EOL;
                    else                          nxt_ch  = ch_idx + 4'd1;
                end
            end
            SEG_EOL: begin
                if (pos == POS_W'(1)) begin
                    nxt_pos = '0;
                    if (dump_en_snap) nxt_seg   = SEG_ERR;
                    else              last_byte = 1'b1;
                end
            end
            SEG_ERR: begin
                if (pos == POS_W'(ERR_LEN - 1)) begin
                    nxt_pos   = '0;
                    last_byte = 1'b1;
                end
            end
        endcase
    end

    // Render the ASCII byte at the next cursor position from the snapshot.
    // Hex digits are counted from the least significant nibble, so the
    // position within a field is mirrored to print MSB first.
    always_comb begin
        nxt_byte = 8'h00;
        digit    = '0;
        shift    = '0;
        unique case (nxt_seg)
            SEG_SEQ: begin
                digit    = POS_W'(SEQ_DIGITS - 1) - nxt_pos;
                shift    = {14'h0, digit, 2'b00};
                nxt_byte = hex_char(4'(seq_snap >> shift));
            end
            SEG_CH: begin
                if (nxt_pos == POS_W'(0))      nxt_byte = 8'h20;
                else if (nxt_pos == POS_W'(1)) nxt_byte = 8'h43;
                else if (nxt_pos == POS_W'(2)) nxt_byte = hex_char(nxt_ch);
                else if (nxt_pos == POS_W'(3)) nxt_byte = 8'h3A;
                else begin
                    digit    = POS_W'(CH_DIGITS + 3) - nxt_pos;
                    shift    = 32'(nxt_ch) * 32'(CH_WIDTH) + {14'h0, digit, 2'b00};
                    nxt_byte = hex_char(4'(ch_snap >> shift));
                end
            end
            SEG_EOL: begin
                nxt_byte = (nxt_pos == POS_W'(0)) ? 8'h0D : 8'h0A;
            end
            SEG_ERR: begin
                if (nxt_pos == POS_W'(0))                        nxt_byte = 8'h45;
                else if (nxt_pos == POS_W'(1))                   nxt_byte = 8'h20;
                else if (nxt_pos < POS_W'(2 + DUMP_DIGITS)) begin
                    digit    = POS_W'(DUMP_DIGITS + 1) - nxt_pos;
                    shift    = {14'h0, digit, 2'b00};
                    nxt_byte = hex_char(4'(dump_a_snap >> shift));
                end
                else if (nxt_pos == POS_W'(2 + DUMP_DIGITS))     nxt_byte = 8'h20;
                else if (nxt_pos < POS_W'(3 + 2 * DUMP_DIGITS)) begin
                    digit    = POS_W'(2 * DUMP_DIGITS + 2) - nxt_pos;
                    shift    = {14'h0, digit, 2'b00};
                    nxt_byte = hex_char(4'(dump_b_snap >> shift));
                end
                else if (nxt_pos == POS_W'(3 + 2 * DUMP_DIGITS)) nxt_byte = 8'h0D;
                else                                             nxt_byte = 8'h0A;
            end
        endcase
    end

    // Period counter, trigger bookkeeping and the frame FSM. The first byte
    // is loaded during SNAP from the live seq, which is the value being
    // captured, so the stream starts on the cycle right after SNAP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            seg          <= SEG_SEQ;
            ch_idx       <= '0;
            pos          <= '0;
            period_cnt   <= '0;
            pending      <= 1'b0;
            overrun      <= 1'b0;
            seq          <= '0;
            seq_snap     <= '0;
            ch_snap      <= '0;
            dump_a_snap  <= '0;
            dump_b_snap  <= '0;
            dump_en_snap <= 1'b0;
            data_q       <= 8'h00;
            valid_q      <= 1'b0;
        end else begin
            if (!enable || tick) period_cnt <= '0;
            else                 period_cnt <= period_cnt + CNT_W'(1);

            // SNAP consumes the pending request; a trigger landing in the
            // same cycle re-arms it rather than counting as an overrun.
            if (state == SNAP) pending <= trigger;
            else if (trigger)  pending <= 1'b1;

            if (trigger && pending && (state != SNAP)) overrun <= 1'b1;

            unique case (state)
                IDLE: begin
                    if (start_ok) state <= SNAP;
                end
                SNAP: begin
                    seq_snap     <= seq;
                    ch_snap      <= ch_data;
                    dump_a_snap  <= dump_a;
                    dump_b_snap  <= dump_b;
                    dump_en_snap <= dump_en;
                    seq          <= seq + SEQ_W'(1);
                    seg          <= SEG_SEQ;
                    ch_idx       <= '0;
                    pos          <= '0;
                    data_q       <= hex_char(4'(seq >> (4 * (SEQ_DIGITS - 1))));
                    valid_q      <= 1'b1;
                    state        <= SEND;
                end
                SEND: begin
                    if (valid_q && tx.ready) begin
                        if (last_byte) begin
                            valid_q <= 1'b0;
                            data_q  <= 8'h00;
                            state   <= start_ok ? SNAP : IDLE;
                        end else begin
                            data_q  <= nxt_byte;
                            seg     <= nxt_seg;
                            ch_idx  <= nxt_ch;
                            pos     <= nxt_pos;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_report_hex_frame.sv
// tb_report_hex_frame
// Bench for report_hex_frame with NUM_CH=2, CH_WIDTH=16, DUMP_WIDTH=8,
// SEQ_DIGITS=2 and a 64-cycle report period. Expected frames are queued as
// hand-written strings; a monitor pops one byte per accepted transfer.
module tb_report_hex_frame;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        force_req = 1'b0;
    logic [31:0] ch_data = '0;
    logic        dump_en = 1'b0;
    logic [7:0]  dump_a = '0;
    logic [7:0]  dump_b = '0;
    logic        busy;
    logic        overrun;

    int          testsRun = 0;
    int          failCount = 0;
    logic [7:0]  expQ[$];

    report_hex_frame_if bus();

    report_hex_frame #(
        .CLK_FREQ   (64),
        .REPORT_FREQ(1),
        .NUM_CH     (2),
        .CH_WIDTH   (16),
        .DUMP_WIDTH (8),
        .SEQ_DIGITS (2)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .enable   (enable),
        .force_req(force_req),
        .ch_data  (ch_data),
        .dump_en  (dump_en),
        .dump_a   (dump_a),
        .dump_b   (dump_b),
        .tx       (bus),
        .busy     (busy),
        .overrun  (overrun)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        testsRun++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic failTimeout(input string name);
        testsRun++;
        failCount++;
        $display("[TB] FAIL %s: event did not occur within its cycle bound", name);
    endtask

    task automatic applyStimulus(input logic en, input logic rdy, input logic [31:0] ch,
                                 input logic de, input logic [7:0] a, input logic [7:0] b);
        enable    = en;
        bus.ready = rdy;
        ch_data   = ch;
        dump_en   = de;
        dump_a    = a;
        dump_b    = b;
    endtask

    task automatic pushFrame(input string s);
        for (int i = 0; i < s.len(); i++) expQ.push_back(s[i]);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic waitDrain(input int bound, input string name);
        bit done;
        done = 1'b0;
        for (int i = 0; i < bound; i++) begin
            step();
            @(negedge clk);
            if (expQ.size() == 0 && !busy) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) failTimeout(name);
    endtask

    // Scoreboard monitor: every accepted byte must match the head of the queue.
    initial begin
        logic [7:0] expByte;
        forever begin
            @(negedge clk);
            if (rst_n && bus.valid && bus.ready) begin
                if (expQ.size() == 0) begin
                    testsRun++;
                    failCount++;
                    $display("[TB] FAIL unexpected_byte: got 0x%0h, expected no byte", bus.data);
                end else begin
                    expByte = expQ.pop_front();
                    checkOutput("stream_byte", 64'(bus.data), 64'(expByte));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int         first;
        bit         seenLow;
        bit         found;
        int         accepts;
        int         busySeen;
        int         validSeen;
        logic [15:0] pattern;

        bus.ready = 1'b0;
        applyStimulus(1'b0, 1'b0, 32'h00FF_1A2B, 1'b0, 8'h00, 8'h00);
        rst_n = 1'b0;
        repeat (3) step();
        @(negedge clk);
        checkOutput("reset_valid", 64'(bus.valid), 64'd0);
        checkOutput("reset_data", 64'(bus.data), 64'd0);
        checkOutput("reset_busy", 64'(busy), 64'd0);
        checkOutput("reset_overrun", 64'(overrun), 64'd0);

        // Periodic frames: first tick in cycle 63, first byte in cycle 65.
        pushFrame("00 C0:1A2B C1:00FF\r\n");
        pushFrame("01 C0:1A2B C1:00FF\r\n");
        step();
        rst_n = 1'b1;
        applyStimulus(1'b1, 1'b1, 32'h00FF_1A2B, 1'b0, 8'h00, 8'h00);
        first = -1;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (c == 63) checkOutput("busy_before_tick", 64'(busy), 64'd0);
            if (c == 64) begin
                checkOutput("snap_busy", 64'(busy), 64'd1);
                checkOutput("snap_valid", 64'(bus.valid), 64'd0);
            end
            if (bus.valid) begin
                first = c;
                break;
            end
        end
        if (first < 0) failTimeout("first_frame");
        else           checkOutput("first_valid_cycle", 64'(first), 64'd65);

        step();
        repeat (24) step();
        @(negedge clk);
        checkOutput("idle_between_frames_busy", 64'(busy), 64'd0);
        repeat (39) step();

        // Second frame under pseudo-random backpressure, channels changed mid-frame.
        pattern = 16'b1011_0110_1101_0011;
        found = 1'b0;
        for (int j = 0; j < 60; j++) begin
            bus.ready = pattern[j % 16];
            if (j == 6) ch_data = 32'hDEAD_BEEF;
            @(negedge clk);
            if (expQ.size() == 0 && !busy) begin
                found = 1'b1;
                break;
            end
            step();
        end
        if (!found) failTimeout("backpressure_frame");
        step();
        applyStimulus(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 8'h00, 8'h00);
        step();
        step();

        // Forced frame with the error line.
        pushFrame("02 C0:BEEF C1:DEAD\r\nE C3 5A\r\n");
        applyStimulus(1'b1, 1'b1, 32'hDEAD_BEEF, 1'b1, 8'hC3, 8'h5A);
        force_req = 1'b1;
        @(negedge clk);
        checkOutput("force_idle_valid", 64'(bus.valid), 64'd0);
        step();
        force_req = 1'b0;
        @(negedge clk);
        checkOutput("force_snap_busy", 64'(busy), 64'd1);
        checkOutput("force_snap_valid", 64'(bus.valid), 64'd0);
        step();
        @(negedge clk);
        checkOutput("force_first_valid", 64'(bus.valid), 64'd1);
        checkOutput("force_first_data", 64'(bus.data), 64'h30);
        waitDrain(60, "force_frame");
        step();
        applyStimulus(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 8'h00, 8'h00);

        // Force while disabled: nothing starts, the request stays pending.
        step();
        force_req = 1'b1;
        step();
        force_req = 1'b0;
        busySeen = 0;
        validSeen = 0;
        repeat (100) begin
            @(negedge clk);
            if (busy) busySeen++;
            if (bus.valid) validSeen++;
            step();
        end
        checkOutput("disabled_valid_cycles", 64'(validSeen), 64'd0);
        checkOutput("disabled_busy_cycles", 64'(busySeen), 64'd0);

        // Re-enable: the pending request starts at once; the next tick comes
        // a full period later because the counter was held at 0.
        pushFrame("03 C0:BEEF C1:DEAD\r\n");
        pushFrame("04 C0:BEEF C1:DEAD\r\n");
        applyStimulus(1'b1, 1'b1, 32'hDEAD_BEEF, 1'b0, 8'h00, 8'h00);
        first = -1;
        seenLow = 1'b0;
        for (int c = 0; c < 120; c++) begin
            @(negedge clk);
            if (c == 1) begin
                checkOutput("pending_snap_valid", 64'(bus.valid), 64'd0);
                checkOutput("pending_snap_busy", 64'(busy), 64'd1);
            end
            if (c == 2) checkOutput("pending_first_valid", 64'(bus.valid), 64'd1);
            if (c > 2 && !bus.valid) seenLow = 1'b1;
            if (seenLow && bus.valid) begin
                first = c;
                break;
            end
        end
        if (first < 0) failTimeout("tick_after_reenable");
        else           checkOutput("tick_after_reenable_cycle", 64'(first), 64'd65);
        waitDrain(60, "tick_frame");
        step();
        applyStimulus(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 8'h00, 8'h00);

        // Overrun: ready held low across two further ticks.
        step();
        pushFrame("05 C0:BEEF C1:DEAD\r\n");
        pushFrame("06 C0:BEEF C1:DEAD\r\n");
        applyStimulus(1'b1, 1'b0, 32'hDEAD_BEEF, 1'b0, 8'h00, 8'h00);
        repeat (65) step();
        @(negedge clk);
        checkOutput("stall_first_valid", 64'(bus.valid), 64'd1);
        checkOutput("stall_first_data", 64'(bus.data), 64'h30);
        repeat (85) step();
        @(negedge clk);
        checkOutput("overrun_after_one_pending", 64'(overrun), 64'd0);
        checkOutput("stall_data_stable", 64'(bus.data), 64'h30);
        repeat (45) step();
        @(negedge clk);
        checkOutput("overrun_set", 64'(overrun), 64'd1);
        repeat (5) step();
        bus.ready = 1'b1;
        for (int i = 0; i < 22; i++) begin
            @(negedge clk);
            if (i == 19) checkOutput("stalled_frame_last_valid", 64'(bus.valid), 64'd1);
            if (i == 20) begin
                checkOutput("gap_valid", 64'(bus.valid), 64'd0);
                checkOutput("gap_busy", 64'(busy), 64'd1);
            end
            if (i == 21) checkOutput("next_frame_valid", 64'(bus.valid), 64'd1);
        end

        // Reset after the seventh byte of the running frame.
        accepts = 1;
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (accepts >= 7) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
            if (bus.valid && bus.ready) accepts++;
        end
        if (!found) failTimeout("seventh_byte");
        step();
        rst_n = 1'b0;
        #1;
        checkOutput("midframe_reset_valid", 64'(bus.valid), 64'd0);
        checkOutput("midframe_reset_data", 64'(bus.data), 64'd0);
        checkOutput("midframe_reset_busy", 64'(busy), 64'd0);
        checkOutput("midframe_reset_overrun", 64'(overrun), 64'd0);
        expQ.delete();
        repeat (3) step();
        pushFrame("00 C0:BEEF C1:DEAD\r\n");
        rst_n = 1'b1;
        waitDrain(150, "post_reset_frame");
        step();
        enable = 1'b0;
        repeat (3) step();
        checkOutput("queue_empty", 64'(expQ.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule

// File: doc/report_hex_frame.md
# report_hex_frame

Periodic, parametrised ASCII status reporter for the verify platform. At a programmable rate, or on demand, it snapshots NUM_CH counter channels and an optional pair of error words. It then streams a CR/LF-terminated hex text frame, one byte at a time, over a valid/ready byte interface into the UART transmitter. It is the generalised successor of the fixed two-counter reporter: configurable channel count, widths and sequence field, plus backpressure-safe handshaking, on-demand triggering and overrun reporting.

## Interface
- CLK_FREQ, 50_000_000, clk frequency in Hz
- REPORT_FREQ, 2, automatic reports per second; REPORT_COUNT = CLK_FREQ/REPORT_FREQ (≥2)
- NUM_CH, 2, number of counter channels, 1..16
- CH_WIDTH, 32, bits per channel, multiple of 4, 4..64
- DUMP_WIDTH, 128, bits per error word, multiple of 4
- SEQ_DIGITS, 3, hex digits of frame sequence number, 1..8
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- enable  in  1  allow periodic/forced frames to start
- force_req  in  1  single-cycle pulse: request a frame now
- ch_data  in  NUM_CH*CH_WIDTH  channel values; channel i at [i*CH_WIDTH +: CH_WIDTH]
- dump_en  in  1  include error line if set at snapshot
- dump_a, dump_b  in  DUMP_WIDTH each  error words (chip result, reference result)
- data  out  8  ASCII byte
- valid  out  1  data holds a byte
- ready  in  1  consumer accepts byte when valid&&ready
- busy  out  1  frame in progress (snapshot cycle through last byte accept)
- overrun  out  1  sticky; set when a trigger arrives while one is already pending

## Operation
- Period counter counts 0..REPORT_COUNT-1 continuously while enable=1. It raises a tick at REPORT_COUNT-1, then wraps to 0. It is held at 0 while enable=0. It keeps running during frames.
- Trigger = tick or force_req. A trigger sets pending. If pending is already set and the trigger is not consumed in the same cycle, overrun is set. Multiple triggers collapse into one frame.
- States: IDLE, SNAP, SEND.
- IDLE -> SNAP when pending && enable.
- In SNAP (one cycle): register ch_data, dump_a, dump_b, dump_en and seq; clear pending (a same-cycle trigger re-sets it); seq increments, wrapping mod 16^SEQ_DIGITS.
- SNAP -> SEND. SEND emits bytes from the registered snapshot only. After the last byte is accepted: -> SNAP if pending && enable, else IDLE.
- Frame byte order:
  - SEQ_DIGITS hex digits of seq, MSB first.
  - For each channel i = 0..NUM_CH-1: ' ', 'C', hex(i), ':', then CH_WIDTH/4 digits MSB first.
  - '\r', '\n'.
  - If snapped dump_en=1, an error line follows: 'E', ' ', DUMP_WIDTH/4 digits of dump_a, ' ', DUMP_WIDTH/4 digits of dump_b, '\r', '\n'.
- Hex digits are uppercase: 0-9 -> 0x30-0x39, A-F -> 0x41-0x46.
- Frame length = SEQ_DIGITS + NUM_CH*(4+CH_WIDTH/4) + 2, plus (DUMP_WIDTH/2 + 5) if the dump line is present.
- enable=0 during SEND does not abort: the current frame completes, and no new frame starts.
- overrun clears only on reset.
- Reset mid-frame: everything returns to reset values immediately. No partial frame resumes.

## Timing
- Reset values: data=0x00, valid=0, busy=0, overrun=0, seq=0, pending=0, period counter=0, state IDLE.
- data and valid are registered.
- Latency: trigger in cycle N sets pending at N+1, giving SNAP at N+1 (if IDLE). The first byte is valid at N+2.
- data is stable while valid=1 && ready=0. Each accept advances to the next byte on the following cycle, so back-to-back accepts give one byte per cycle.
- valid is low in IDLE and SNAP. Consecutive frames are therefore separated by exactly one valid=0 cycle.
- busy is high from SNAP through the cycle of the last accept.

## Test plan
- NUM_CH=2, CH_WIDTH=16, SEQ_DIGITS=2, REPORT_COUNT=64, ch0=0x1A2B, ch1=0x00FF, ready=1 -> exactly 20 bytes "00 C0:1A2B C1:00FF\r\n". The first tick occurs at cycle 63 and valid rises 2 cycles later. The next frame carries seq "01".
- Same configuration with ready toggled pseudo-randomly, and ch_data changed mid-frame -> byte stream identical to the snapshot values, with no byte dropped or duplicated.
- dump_en=1, DUMP_WIDTH=8, dump_a=0xC3, dump_b=0x5A -> the line above is followed by "E C3 5A\r\n", for 29 bytes total.
- ready held 0 across two ticks -> overrun=1. After ready is released: one frame completes, one valid=0 cycle, then the next frame starts.
- force_req pulse with a long REPORT_COUNT and enable=1 -> frame starts 1 cycle later. With enable=0 -> no frame, and the period counter is held at 0.
- Assert rst_n low at byte 7 of a frame -> valid=0, data=0x00 and busy=0 immediately. After release, the first frame shows seq "00".
